// File: rtl/ex_alu_issue_if.sv
// Bus bundle between decode, the execute issue controller, the ALU and the memory stage.
// slave is the issue controller's view; master is the surrounding pipeline and ALU.
interface ex_alu_issue_if #(
  parameter int unsigned OP_W   = 19,
  parameter int unsigned DEST_W = 5
);
  logic              ds_to_es_valid;
  logic              es_allowin;
  logic [OP_W-1:0]   ds_op;
  logic [31:0]       ds_src1;
  logic [31:0]       ds_src2;
  logic [DEST_W-1:0] ds_dest;

  logic [OP_W-1:0]   alu_op;
  logic [31:0]       alu_src1;
  logic [31:0]       alu_src2;
  logic [31:0]       alu_result;
  logic              alu_complete;

  logic              es_to_ms_valid;
  logic              ms_allowin;
  logic [31:0]       es_result;
  logic [DEST_W-1:0] es_dest;
  logic              flush;

  modport slave (
    input  ds_to_es_valid, ds_op, ds_src1, ds_src2, ds_dest,
    input  alu_result, alu_complete, ms_allowin, flush,
    output es_allowin, alu_op, alu_src1, alu_src2,
    output es_to_ms_valid, es_result, es_dest
  );

  modport master (
    output ds_to_es_valid, ds_op, ds_src1, ds_src2, ds_dest,
    output alu_result, alu_complete, ms_allowin, flush,
    input  es_allowin, alu_op, alu_src1, alu_src2,
    input  es_to_ms_valid, es_result, es_dest
  );
endinterface

// File: rtl/ex_alu_issue.sv
// Execute-stage issue/hold controller: holds one operation on the ALU until it
// completes, then holds the result until the memory stage takes it.
module ex_alu_issue #(
  parameter int unsigned OP_W   = 19,
  parameter int unsigned DEST_W = 5
) (
  input  logic           clk,
  input  logic           resetn,
  ex_alu_issue_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              allowin;
  logic              accept;
  logic              capture;

  logic [OP_W-1:0]   alu_op_q;
  logic [31:0]       src1_q;
  logic [31:0]       src2_q;
  logic [DEST_W-1:0] dest_q;
  logic [31:0]       result_q;

  // Next-state and handshake decode; flush outranks accept and completion.
  always_comb begin
    state_nxt = state;
    allowin   = (state == IDLE) | ((state == DONE) & bus.ms_allowin);
    accept    = bus.ds_to_es_valid & allowin & ~bus.flush;
    capture   = (state == BUSY) & bus.alu_complete & ~bus.flush;
    case (state)
      IDLE: begin
        if (accept) state_nxt = BUSY;
      end
      BUSY: begin
        if (bus.flush)             state_nxt = IDLE;
        else if (bus.alu_complete) state_nxt = DONE;
      end
      DONE: begin
        if (bus.flush)           state_nxt = IDLE;
        else if (bus.ms_allowin) state_nxt = accept ? BUSY : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // The ALU sees a nonzero opcode only while BUSY, so every op is framed by a zero cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      alu_op_q <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      dest_q   <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        src1_q <= bus.ds_src1;
        src2_q <= bus.ds_src2;
        dest_q <= bus.ds_dest;
      end
      if (capture) result_q <= bus.alu_result;
      if (state_nxt == BUSY) alu_op_q <= accept ? bus.ds_op : alu_op_q;
      else                   alu_op_q <= '0;
    end
  end

  assign bus.es_allowin     = allowin;
  assign bus.alu_op         = alu_op_q;
  assign bus.alu_src1       = src1_q;
  assign bus.alu_src2       = src2_q;
  assign bus.es_to_ms_valid = (state == DONE);
  assign bus.es_result      = result_q;
  assign bus.es_dest        = dest_q;

endmodule

// File: tb/tb_ex_alu_issue.sv
// Bench for ex_alu_issue: behavioural ALU with multi-cycle mul/div, directed vector
// table plus hand-written back-pressure, back-to-back, flush and async-reset sequences.
module tb_ex_alu_issue;

  localparam int unsigned OP_W   = 19;
  localparam int unsigned DEST_W = 5;
  localparam int unsigned DIV_N  = 6;
  localparam int unsigned N_VEC  = 10;

  typedef struct {
    string             name;
    logic [OP_W-1:0]   op;
    logic [31:0]       s1;
    logic [31:0]       s2;
    logic [DEST_W-1:0] dest;
    logic [31:0]       res;
    int                busy;
  } vec_t;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs [N_VEC];

  ex_alu_issue_if #(.OP_W(OP_W), .DEST_W(DEST_W)) bus ();

  ex_alu_issue #(.OP_W(OP_W), .DEST_W(DEST_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // ALU model: counts cycles of a continuously nonzero opcode; mul finishes on the
  // 2nd cycle, div/mod on cycle DIV_N+1, everything else (and NOP) immediately.
  logic [7:0] alu_cnt;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)              alu_cnt <= '0;
    else if (bus.alu_op == '0) alu_cnt <= '0;
    else                      alu_cnt <= alu_cnt + 8'd1;
  end

  always_comb begin
    bus.alu_result   = '0;
    bus.alu_complete = 1'b1;
    if (|bus.alu_op[18:15]) begin
      bus.alu_complete = (alu_cnt == 8'(DIV_N));
      if (bus.alu_src2 != '0)
        bus.alu_result = (|bus.alu_op[16:15]) ? bus.alu_src1 / bus.alu_src2
                                              : bus.alu_src1 % bus.alu_src2;
    end else if (|bus.alu_op[14:12]) begin
      bus.alu_complete = (alu_cnt == 8'd1);
      bus.alu_result   = bus.alu_src1 * bus.alu_src2;
    end else if (bus.alu_op[0]) bus.alu_result = bus.alu_src1 + bus.alu_src2;
    else if (bus.alu_op[1])     bus.alu_result = bus.alu_src1 - bus.alu_src2;
    else if (bus.alu_op[2])     bus.alu_result = bus.alu_src1 & bus.alu_src2;
    else if (bus.alu_op[3])     bus.alu_result = bus.alu_src1 | bus.alu_src2;
    else if (bus.alu_op[4])     bus.alu_result = bus.alu_src1 ^ bus.alu_src2;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [OP_W-1:0] op, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [DEST_W-1:0] d);
    bus.ds_to_es_valid = 1'b1;
    bus.ds_op          = op;
    bus.ds_src1        = s1;
    bus.ds_src2        = s2;
    bus.ds_dest        = d;
  endtask

  // Called at posedge+1 in IDLE with ms_allowin=1; returns at posedge+1 back in IDLE.
  task automatic run_op(input vec_t v);
    int   busy;
    logic hold_ok;
    chk({v.name, " allowin idle"}, 32'(bus.es_allowin), 32'd1);
    drive(v.op, v.s1, v.s2, v.dest);
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    bus.ds_op   = ~v.op;
    bus.ds_src1 = ~v.s1;
    bus.ds_src2 = ~v.s2;
    bus.ds_dest = ~v.dest;
    busy    = 0;
    hold_ok = 1'b1;
    while (!bus.es_to_ms_valid && busy < 64) begin
      if (bus.alu_op !== v.op || bus.alu_src1 !== v.s1 || bus.alu_src2 !== v.s2 ||
          bus.es_allowin !== 1'b0) hold_ok = 1'b0;
      busy++;
      @(posedge clk); #1;
    end
    chk({v.name, " busy cycles"}, 32'(busy), 32'(v.busy));
    chk({v.name, " busy hold"}, 32'(hold_ok), 32'd1);
    chk({v.name, " result"}, bus.es_result, v.res);
    chk({v.name, " dest"}, 32'(bus.es_dest), 32'(v.dest));
    chk({v.name, " alu_op zero in done"}, 32'(bus.alu_op), 32'd0);
    @(posedge clk); #1;
    chk({v.name, " valid drops"}, 32'(bus.es_to_ms_valid), 32'd0);
  endtask

  initial begin
    int   cyc;
    int   nv;
    int   n_acc;
    int   runs;
    int   t1;
    int   t2;
    logic acc;
    logic prev_nz;
    logic ok;
    logic [31:0] r1;
    logic [31:0] r2;
    vec_t v;

    vecs[0] = '{"add",  19'h00001, 32'd5,          32'd7,          5'd3,  32'd12,         1};
    vecs[1] = '{"sub",  19'h00002, 32'd10,         32'd3,          5'd4,  32'd7,          1};
    vecs[2] = '{"and",  19'h00004, 32'h0000F0F0,   32'h0000FF00,   5'd5,  32'h0000F000,   1};
    vecs[3] = '{"xor",  19'h00010, 32'hAAAA5555,   32'hFFFFFFFF,   5'd6,  32'h5555AAAA,   1};
    vecs[4] = '{"nop",  19'h00000, 32'd123,        32'd456,        5'd7,  32'd0,          1};
    vecs[5] = '{"mul",  19'h01000, 32'hFFFFFFFF,   32'd3,          5'd8,  32'hFFFFFFFD,   2};
    vecs[6] = '{"mulh", 19'h02000, 32'd1000,       32'd1000,       5'd9,  32'd1000000,    2};
    vecs[7] = '{"div",  19'h08000, 32'd100,        32'd7,          5'd10, 32'd14,         DIV_N + 1};
    vecs[8] = '{"mod",  19'h20000, 32'd100,        32'd7,          5'd11, 32'd2,          DIV_N + 1};
    vecs[9] = '{"divu", 19'h10000, 32'd50,         32'd5,          5'd31, 32'd10,         DIV_N + 1};

    bus.ds_to_es_valid = 1'b0;
    bus.ds_op          = '0;
    bus.ds_src1        = '0;
    bus.ds_src2        = '0;
    bus.ds_dest        = '0;
    bus.ms_allowin     = 1'b1;
    bus.flush          = 1'b0;

    // Reset values, then accept on the first edge after release
    #1 resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst alu_op",   32'(bus.alu_op), 32'd0);
    chk("rst alu_src1", bus.alu_src1, 32'd0);
    chk("rst alu_src2", bus.alu_src2, 32'd0);
    chk("rst valid",    32'(bus.es_to_ms_valid), 32'd0);
    chk("rst allowin",  32'(bus.es_allowin), 32'd1);
    chk("rst result",   bus.es_result, 32'd0);
    chk("rst dest",     32'(bus.es_dest), 32'd0);
    resetn = 1'b1;

    for (int i = 0; i < int'(N_VEC); i++) run_op(vecs[i]);

    // Divide with memory-stage back-pressure
    bus.ms_allowin = 1'b0;
    drive(19'h08000, 32'd100, 32'd7, 5'd12);
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    cyc = 0;
    ok  = 1'b1;
    while (!bus.es_to_ms_valid && cyc < 64) begin
      if (bus.alu_op !== 19'h08000 || bus.es_allowin !== 1'b0) ok = 1'b0;
      cyc++;
      @(posedge clk); #1;
    end
    chk("bp busy cycles", 32'(cyc), 32'(DIV_N + 1));
    chk("bp op held", 32'(ok), 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (bus.es_to_ms_valid !== 1'b1 || bus.es_result !== 32'd14 || bus.es_dest !== 5'd12 ||
          bus.es_allowin !== 1'b0 || bus.alu_op !== '0) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("bp done stable", 32'(ok), 32'd1);
    bus.ms_allowin = 1'b1;
    drive(19'h00001, 32'd1, 32'd2, 5'd13);
    #1;
    chk("bp release allowin", 32'(bus.es_allowin), 32'd1);
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    chk("bp same-cycle accept op", 32'(bus.alu_op), 32'h00001);
    chk("bp valid low in busy", 32'(bus.es_to_ms_valid), 32'd0);
    @(posedge clk); #1;
    chk("bp next result", bus.es_result, 32'd3);
    chk("bp next dest", 32'(bus.es_dest), 32'd13);
    @(posedge clk); #1;

    // Back-to-back multiplies with ms_allowin held high
    drive(19'h01000, 32'hFFFFFFFF, 32'd3, 5'd20);
    n_acc = 0; nv = 0; runs = 0; prev_nz = 1'b0;
    t1 = -1; t2 = -1; r1 = '0; r2 = '0;
    for (int c = 0; c < 20; c++) begin
      acc = bus.ds_to_es_valid & bus.es_allowin;
      @(posedge clk); #1;
      if (acc) begin
        n_acc++;
        if (n_acc == 1) drive(19'h01000, 32'd7, 32'd6, 5'd21);
        else            bus.ds_to_es_valid = 1'b0;
      end
      if (bus.alu_op != '0 && !prev_nz) runs++;
      prev_nz = (bus.alu_op != '0);
      if (bus.es_to_ms_valid) begin
        if (nv == 0)      begin t1 = c; r1 = bus.es_result; end
        else if (nv == 1) begin t2 = c; r2 = bus.es_result; end
        nv++;
      end
    end
    bus.ds_to_es_valid = 1'b0;
    chk("b2b separate alu runs", 32'(runs), 32'd2);
    chk("b2b valid pulses", 32'(nv), 32'd2);
    chk("b2b first result", r1, 32'hFFFFFFFD);
    chk("b2b second result", r2, 32'd42);
    chk("b2b pulse spacing", 32'(t2 - t1), 32'd3);

    // Flush in IDLE blocks the accept and otherwise does nothing
    drive(19'h00001, 32'd9, 32'd9, 5'd1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.ds_to_es_valid = 1'b0;
    chk("flush idle no accept", 32'(bus.alu_op), 32'd0);
    chk("flush idle allowin", 32'(bus.es_allowin), 32'd1);

    // Flush on the 3rd BUSY cycle of a divide
    drive(19'h08000, 32'd100, 32'd7, 5'd14);
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("flush div op before", 32'(bus.alu_op), 32'h08000);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush div op killed", 32'(bus.alu_op), 32'd0);
    chk("flush div idle", 32'(bus.es_allowin), 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus.es_to_ms_valid !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("flush div never valid", 32'(ok), 32'd1);
    v = '{"div2", 19'h08000, 32'd50, 32'd5, 5'd15, 32'd10, DIV_N + 1};
    run_op(v);

    // Flush coinciding with completion must not capture the result
    drive(19'h00001, 32'd20, 32'd22, 5'd2);
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush capture valid", 32'(bus.es_to_ms_valid), 32'd0);
    chk("flush capture result kept", bus.es_result, 32'd10);

    // Flush while holding a result in DONE
    bus.ms_allowin = 1'b0;
    drive(19'h00001, 32'd1, 32'd1, 5'd1);
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush done pre valid", 32'(bus.es_to_ms_valid), 32'd1);
    chk("flush done pre result", bus.es_result, 32'd2);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.ms_allowin = 1'b1;
    chk("flush done valid drops", 32'(bus.es_to_ms_valid), 32'd0);
    chk("flush done allowin", 32'(bus.es_allowin), 32'd1);

    // Async reset in the middle of a multiply
    drive(19'h01000, 32'd3, 32'd4, 5'd22);
    @(posedge clk); #1;
    bus.ds_to_es_valid = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("areset alu_op",   32'(bus.alu_op), 32'd0);
    chk("areset alu_src1", bus.alu_src1, 32'd0);
    chk("areset alu_src2", bus.alu_src2, 32'd0);
    chk("areset result",   bus.es_result, 32'd0);
    chk("areset dest",     32'(bus.es_dest), 32'd0);
    chk("areset valid",    32'(bus.es_to_ms_valid), 32'd0);
    chk("areset allowin",  32'(bus.es_allowin), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    run_op(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
